aes_round_engine: RTL and testbench

Iterative AES-128 encryption datapath that consumes the ten expanded round keys and the cipher key, and produces one ciphertext block per accepted plaintext block. It sits directly downstream of the key expansion stage. It performs the initial AddRoundKey on acceptance, then one full cipher round per clock. Results are held behind a valid/ready output handshake.

---
 rtl/aes_pkg.sv | 48 ++++
 rtl/aes_round_comb.sv | 53 +++++
 rtl/aes_round_engine.sv | 122 ++++++++++++
 tb/tb_aes_round_engine.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 constants, FSM encoding and GF(2^8) helpers
//
// Purpose: common definitions for the iterative AES-128 round engine.
//   NUM_ROUNDS   : cipher rounds for AES-128
//   AES_BLOCK_W  : block / key width in bits
//   fsm_state_e  : 2-bit engine FSM encoding
//   sbox()       : forward S-box lookup (256-entry table)
//   xtime()      : multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
package aes_pkg;

  localparam int NUM_ROUNDS  = 10;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_e;

  // Entry 0x00 sits in the top byte; entry n is at bits [2047-8n -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// rtl/aes_round_comb.sv - one combinational AES-128 encryption round
//
// Purpose: SubBytes -> ShiftRows -> MixColumns (skipped on the final round)
//          -> AddRoundKey, all in one combinational cloud.
// Ports:
//   state_i       in  128 : current cipher state, byte 0 = bits [127:120]
//   round_key_i   in  128 : round key for this round
//   final_round_i in  1   : bypass MixColumns (round 10)
//   next_state_o  out 128 : state after the round
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] round_key_i,
  input  logic         final_round_i,
  output logic [127:0] next_state_o
);

  // Byte index i maps to row i%4, column i/4 (column-major state).
  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb[i] = sbox(state_i[127-8*i -: 8]);
  end

  // Row r rotates left by r: output (r,c) takes input (r,(c+r)%4).
  for (genvar c = 0; c < 4; c++) begin : g_shift_col
    for (genvar r = 0; r < 4; r++) begin : g_shift_row
      assign sr[4*c+r] = sb[4*((c+r)%4)+r];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*c+0];
    assign a1 = sr[4*c+1];
    assign a2 = sr[4*c+2];
    assign a3 = sr[4*c+3];
    // 3*a is xtime(a) ^ a.
    assign mc[4*c+0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign next_state_o[127-8*i -: 8] =
      (final_round_i ? sr[i] : mc[i]) ^ round_key_i[127-8*i -: 8];
  end

endmodule

// File: rtl/aes_round_engine.sv
// rtl/aes_round_engine.sv - iterative AES-128 encryption engine, one round per clock
//
// Purpose: accepts a plaintext block with its expanded keys, applies the
//          initial AddRoundKey on acceptance, then runs rounds 1..10 on
//          successive clocks and holds the ciphertext behind valid/ready.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   in_valid / in_ready        : input handshake (in_ready only in IDLE)
//   plaintext, key             : block and round key 0
//   round_key_1..round_key_10  : expanded round keys, stable while BUSY
//   out_valid / out_ready      : output handshake (out_valid only in DONE)
//   ciphertext                 : encrypted block (the state register)
module aes_round_engine #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  input  logic [127:0] round_key_1,
  input  logic [127:0] round_key_2,
  input  logic [127:0] round_key_3,
  input  logic [127:0] round_key_4,
  input  logic [127:0] round_key_5,
  input  logic [127:0] round_key_6,
  input  logic [127:0] round_key_7,
  input  logic [127:0] round_key_8,
  input  logic [127:0] round_key_9,
  input  logic [127:0] round_key_10,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  fsm_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] round_key;
  logic [127:0] round_out;

  // Keys are not registered here; the upstream key stage holds them stable.
  always_comb begin
    round_key = '0;
    case (round_q)
      4'd1:    round_key = round_key_1;
      4'd2:    round_key = round_key_2;
      4'd3:    round_key = round_key_3;
      4'd4:    round_key = round_key_4;
      4'd5:    round_key = round_key_5;
      4'd6:    round_key = round_key_6;
      4'd7:    round_key = round_key_7;
      4'd8:    round_key = round_key_8;
      4'd9:    round_key = round_key_9;
      4'd10:   round_key = round_key_10;
      default: round_key = '0;
    endcase
  end

  aes_round_comb u_round (
    .state_i       (state_q),
    .round_key_i   (round_key),
    .final_round_i (round_q == LAST_ROUND),
    .next_state_o  (round_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = plaintext ^ key;
          round_d = 4'd1;
          fsm_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        state_d = round_out;
        // round_q parks at the last round while DONE so it never exceeds 10.
        if (round_q == LAST_ROUND) begin
          fsm_d = ST_DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          fsm_d   = ST_IDLE;
          round_d = 4'd0;
        end
      end
      default: begin
        fsm_d   = ST_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  assign in_ready   = (fsm_q == ST_IDLE);
  assign out_valid  = (fsm_q == ST_DONE);
  assign ciphertext = state_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// tb/tb_aes_round_engine.sv - directed FIPS-197 vector bench for aes_round_engine
module tb_aes_round_engine;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] S0_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK_B [1:10] = '{
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK_C [1:10] = '{
    128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe,
    128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd,
    128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b,
    128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2,
    128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5
  };

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] rk [1:10];
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_round_engine dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .plaintext    (plaintext),
    .key          (key),
    .round_key_1  (rk[1]),
    .round_key_2  (rk[2]),
    .round_key_3  (rk[3]),
    .round_key_4  (rk[4]),
    .round_key_5  (rk[5]),
    .round_key_6  (rk[6]),
    .round_key_7  (rk[7]),
    .round_key_8  (rk[8]),
    .round_key_9  (rk[9]),
    .round_key_10 (rk[10]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ciphertext   (ciphertext)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_b;
    plaintext = PT_B;
    key       = KEY_B;
    for (int i = 1; i <= 10; i++) rk[i] = RK_B[i];
  endtask

  task automatic load_c;
    plaintext = PT_C;
    key       = KEY_C;
    for (int i = 1; i <= 10; i++) rk[i] = RK_C[i];
  endtask

  task automatic accept;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int max, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < max) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int           cyc;
    int           nacc;
    int           nres;
    int           pulses;
    int           acc_cyc [2];
    logic [127:0] res [2];
    logic [127:0] held;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;
    for (int i = 1; i <= 10; i++) rk[i] = '0;

    // Reset values
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_ciphertext", ciphertext, 0);
    check("rst_round_q", dut.round_q, 0);
    reset = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);

    // App. B with 20 cycles of backpressure
    load_b();
    accept();
    check("b_state_after_accept", dut.state_q, S0_B);
    check("b_busy_in_ready", in_ready, 0);
    check("b_round_q_1", dut.round_q, 1);
    wait_out(30, cyc);
    check("b_latency", cyc, 10);
    check("b_ciphertext", ciphertext, CT_B);
    held = ciphertext;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_ciphertext", ciphertext, held);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_round_q", dut.round_q, 0);

    // App. C.1
    load_c();
    out_ready = 1'b1;
    accept();
    wait_out(30, cyc);
    check("c_latency", cyc, 10);
    check("c_ciphertext", ciphertext, CT_C);
    tick();
    check("c_back_to_idle", in_ready, 1);

    // Back-to-back: B then C with in_valid held high
    load_b();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    nacc = 0;
    nres = 0;
    acc_cyc[0] = -1;
    acc_cyc[1] = -1;
    res[0] = '0;
    res[1] = '0;
    while (nres < 2 && cyc < 80) begin
      if (in_valid && in_ready && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      if (out_valid && out_ready && nres < 2) begin
        res[nres] = ciphertext;
        nres++;
      end
      tick();
      cyc++;
      if (nacc == 2) in_valid = 1'b0;
      if (nres == 1 && nacc == 1) load_c();
    end
    in_valid = 1'b0;
    check("b2b_accept_count", nacc, 2);
    check("b2b_result_count", nres, 2);
    check("b2b_interval", acc_cyc[1] - acc_cyc[0], 12);
    check("b2b_first_ct", res[0], CT_B);
    check("b2b_second_ct", res[1], CT_C);
    check("b2b_idle_after", in_ready, 1);

    // Reset abort during round 5
    load_b();
    out_ready = 1'b1;
    accept();
    for (int i = 0; i < 4; i++) tick();
    check("abort_round_q_5", dut.round_q, 5);
    #3;
    reset = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_ciphertext", ciphertext, 0);
    check("abort_round_q", dut.round_q, 0);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("abort_no_out_valid", pulses, 0);
    check("abort_idle", in_ready, 1);
    accept();
    wait_out(30, cyc);
    check("abort_rerun_latency", cyc, 10);
    check("abort_rerun_ct", ciphertext, CT_B);
    tick();

    // in_valid pulsed during BUSY with a different plaintext
    load_b();
    out_ready = 1'b1;
    accept();
    for (int i = 0; i < 3; i++) tick();
    plaintext = PT_C;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    plaintext = PT_B;
    wait_out(30, cyc);
    check("busy_pulse_latency", cyc, 6);
    check("busy_pulse_ct", ciphertext, CT_B);
    tick();
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) pulses++;
      tick();
    end
    check("busy_pulse_no_second", pulses, 0);
    check("busy_pulse_idle", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
